// File: rtl/pfa32_pkg.sv
// Shared constants and types for the pfa32 Kogge-Stone adder.
// PFA32_PIPE_EN selects the pipelined build; PFA32_LAT follows it.
package pfa32_pkg;

    localparam int PFA32_W   = 32;
    localparam int PFA32_LVL = 5;

`ifdef PFA32_PIPE_EN
    localparam int PFA32_LAT = 3;
`else
    localparam int PFA32_LAT = 2;
`endif

    typedef logic [31:0] pfa32_vec_t;

    // Distance between combined positions at prefix level lvl (1-based).
    function automatic int pfa32_span(input int lvl);
        return 1 << (lvl - 1);
    endfunction

endpackage

// File: rtl/pfa_black_cell.sv
// Kogge-Stone black cell: merges a high group (gh, ph) with the adjacent
// low group (gl, pl). Used as a gray cell when p is left unused.
module pfa_black_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/pfa32.sv
// Registered 32-bit Kogge-Stone adder: {cout, s} = a + b + cin.
// Optional macro PFA32_PIPE_EN adds a register stage after prefix level 3.
module pfa32
    import pfa32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PFA32_W-1:0] a,
    input  logic [PFA32_W-1:0] b,
    input  logic               cin,
    output logic [PFA32_W-1:0] s,
    output logic               cout
);

    // Streaming datapath: no valid/ready; every clock accepts one operand
    // set and retires one result, with no stall path.

    pfa32_vec_t a_q, b_q;
    logic       cin_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
        end
    end

    pfa32_vec_t g_bit, p_bit;
    assign g_bit = a_q & b_q;
    assign p_bit = a_q ^ b_q;

    // g_lvl[n]/p_lvl[n] are the group terms after prefix level n;
    // g_op/p_op are what level n+1 consumes (registered at level 3 if piped).
    logic [PFA32_LVL:0][PFA32_W-1:0]   g_lvl;
    logic [PFA32_LVL-1:0][PFA32_W-1:0] p_lvl;
    logic [PFA32_LVL-1:0][PFA32_W-1:0] g_op;
    logic [PFA32_LVL-1:0][PFA32_W-1:0] p_op;
    pfa32_vec_t                        p_sum;
    logic                              cin_sum;

    // cin sits at position -1; merging it into bit 0 up front keeps the
    // tree at 32 positions so five levels reach every bit.
    pfa_black_cell u_cin_fold (
        .gh (g_bit[0]),
        .ph (p_bit[0]),
        .gl (cin_q),
        .pl (1'b0),
        .g  (g_lvl[0][0]),
        .p  (p_lvl[0][0])
    );

    for (genvar k = 1; k < PFA32_W; k++) begin : g_lvl0
        assign g_lvl[0][k] = g_bit[k];
        assign p_lvl[0][k] = p_bit[k];
    end

    for (genvar l = 0; l < PFA32_LVL; l++) begin : g_opsel
        if (l != 3) begin : g_direct
            assign g_op[l] = g_lvl[l];
            assign p_op[l] = p_lvl[l];
        end
    end

`ifdef PFA32_PIPE_EN
    pfa32_vec_t g3_q, p3_q, psum_q;
    logic       cin3_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g3_q   <= '0;
            p3_q   <= '0;
            psum_q <= '0;
            cin3_q <= 1'b0;
        end else begin
            g3_q   <= g_lvl[3];
            p3_q   <= p_lvl[3];
            psum_q <= p_bit;
            cin3_q <= cin_q;
        end
    end

    assign g_op[3] = g3_q;
    assign p_op[3] = p3_q;
    assign p_sum   = psum_q;
    assign cin_sum = cin3_q;
`else
    assign g_op[3] = g_lvl[3];
    assign p_op[3] = p_lvl[3];
    assign p_sum   = p_bit;
    assign cin_sum = cin_q;
`endif

    // Levels 1..4 need both G and P downstream: full black cells.
    for (genvar l = 1; l < PFA32_LVL; l++) begin : g_tree
        localparam int D = pfa32_span(l);
        for (genvar k = 0; k < PFA32_W; k++) begin : g_bitpos
            if (k >= D) begin : g_cell
                pfa_black_cell u_bc (
                    .gh (g_op[l-1][k]),
                    .ph (p_op[l-1][k]),
                    .gl (g_op[l-1][k-D]),
                    .pl (p_op[l-1][k-D]),
                    .g  (g_lvl[l][k]),
                    .p  (p_lvl[l][k])
                );
            end else begin : g_pass
                assign g_lvl[l][k] = g_op[l-1][k];
                assign p_lvl[l][k] = p_op[l-1][k];
            end
        end
    end

    // Last level only needs G: black cells acting as gray cells.
    localparam int LAST_D = pfa32_span(PFA32_LVL);
    logic [PFA32_W-1:LAST_D] gray_p_unused;

    for (genvar k = 0; k < PFA32_W; k++) begin : g_last
        if (k >= LAST_D) begin : g_gray
            pfa_black_cell u_gc (
                .gh (g_op[PFA32_LVL-1][k]),
                .ph (p_op[PFA32_LVL-1][k]),
                .gl (g_op[PFA32_LVL-1][k-LAST_D]),
                .pl (p_op[PFA32_LVL-1][k-LAST_D]),
                .g  (g_lvl[PFA32_LVL][k]),
                .p  (gray_p_unused[k])
            );
        end else begin : g_pass
            assign g_lvl[PFA32_LVL][k] = g_op[PFA32_LVL-1][k];
        end
    end

    // g_lvl[5][i] spans bits [i:-1], so it is the carry into bit i+1.
    pfa32_vec_t carry, s_d, s_q;
    logic       cout_d, cout_q;

    assign carry  = {g_lvl[PFA32_LVL][PFA32_W-2:0], cin_sum};
    assign s_d    = p_sum ^ carry;
    assign cout_d = g_lvl[PFA32_LVL][PFA32_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_pfa32.sv
// Self-checking bench for pfa32: directed vectors, mid-stream reset and
// random streaming against a 33-bit reference sum, in either build.
module tb_pfa32;
  import pfa32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        cin;
  logic [31:0] s;
  logic        cout;

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_bad = 0;

  pfa32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {cout,s}=%h expected %h", tag, got, exp);
    end
  endtask

  // Each negedge: retire the result due now, then drive the next operands.
  task automatic cycle(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic [32:0] vexp);
    logic [32:0] e;
    @(negedge clk);
    if (exp_q.size() == PFA32_LAT) begin
      e = exp_q.pop_front();
      check_eq(tag, {cout, s}, e);
    end
    a   = va;
    b   = vb;
    cin = vc;
    exp_q.push_back(vexp);
  endtask

  task automatic cycle_model(input string tag, input logic [31:0] va, input logic [31:0] vb,
                             input logic vc);
    cycle(tag, va, vb, vc, {1'b0, va} + {1'b0, vb} + {32'd0, vc});
  endtask

  // Called at a negedge after a reset edge: registers hold zeros, so the
  // first LAT-1 results are 0+0+0 before the operands driven here emerge.
  task automatic release_reset();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < PFA32_LAT - 1; i++) exp_q.push_back(33'd0);
    a   = 32'd0;
    b   = 32'd0;
    cin = 1'b0;
    exp_q.push_back(33'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    cin   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset", {cout, s}, 33'd0);
    release_reset();

    cycle("v_alt",     32'h00FF_00FF, 32'hFF00_FF00, 1'b0, 33'h0_FFFF_FFFF);
    cycle("v_ripple",  32'hF3FF_00FF, 32'h0C00_FF00, 1'b1, 33'h1_0000_0000);
    cycle("v_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
    cycle("v_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
    cycle("v_cin_max", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
    cycle("v_zero",    32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000);
    cycle("v_mix",     32'h1234_5678, 32'h8765_4321, 1'b1, 33'h0_9999_999A);
    cycle("v_hibit",   32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);

    // Reset with non-zero results in flight: they must be dropped.
    cycle_model("pre_rst", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    cycle_model("pre_rst", 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    a     = 32'hFFFF_0000;
    b     = 32'h0001_FFFF;
    cin   = 1'b1;
    @(negedge clk);
    check_eq("rst_mid", {cout, s}, 33'd0);
    release_reset();
    cycle_model("post_rst", 32'h0000_0003, 32'h0000_0004, 1'b1);
    cycle_model("post_rst", 32'hC000_0000, 32'h4000_0000, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      cycle_model("rand", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < PFA32_LAT; i++) cycle_model("drain", 32'd0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
